// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings used by the memory tester and its helpers.
package ahb_lite_pkg;

  // HTRANS codes
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HBURST codes
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  // HSIZE codes
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb_lite_lane_pattern.sv
// Test pattern and active-lane mask for one beat address.
module ahb_lite_lane_pattern
  import ahb_lite_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic        pattern,
  output logic [31:0] data,
  output logic [31:0] mask
);

  logic [31:0] pat;

  // Replicate the narrow pattern across all lanes; mask picks the little-endian lane(s).
  always_comb begin
    pat  = pattern ? ~addr : addr;
    data = pat;
    mask = 32'hffff_ffff;
    case (size)
      HSIZE_BYTE: begin
        data = {4{pat[7:0]}};
        mask = 32'h0000_00ff << {addr[1:0], 3'b000};
      end
      HSIZE_HALF: begin
        data = {2{pat[15:0]}};
        mask = addr[1] ? 32'hffff_0000 : 32'h0000_ffff;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite master that writes a pattern to a memory range, then reads it back and checks it.
module ahb_lite_mem_tester
  import ahb_lite_pkg::*;
#(
  parameter int unsigned WORD_COUNT = 16,
  parameter int unsigned DATA_SIZE  = 2,
  parameter int unsigned PATTERN    = 0,
  parameter int unsigned USE_BURST  = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        START,
  input  logic [31:0] STARTADDR,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic        HSEL,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [31:0] ERRCOUNT,
  output logic [15:0] CHKCOUNT,
  output logic        S_WRITE,
  output logic        S_CHECK,
  output logic        S_SUCCESS,
  output logic        S_FAILED
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [16:0] WcLast   = 17'(WORD_COUNT - 1);
  localparam logic [16:0] WcTotal  = 17'(WORD_COUNT);
  localparam logic [2:0]  Size     = 3'(DATA_SIZE);
  localparam logic [31:0] AddrInc  = 32'd1 << DATA_SIZE;
  localparam logic [1:0]  NextTrans = (USE_BURST != 0) ? HTRANS_SEQ : HTRANS_NONSEQ;

  logic [1:0]  state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic        hsel_q, hsel_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q, dp_write_d;
  logic [31:0] exp_q, exp_d;
  logic [31:0] mask_q, mask_d;
  logic [16:0] issue_cnt_q, issue_cnt_d;
  logic [16:0] done_cnt_q, done_cnt_d;
  logic [31:0] errcount_q, errcount_d;
  logic [15:0] chkcount_q, chkcount_d;

  logic [31:0] lp_data, lp_mask;
  logic        mismatch;

  // Pattern and mask for the address currently on the bus; captured when it is accepted.
  ahb_lite_lane_pattern u_lane_pattern (
    .addr    (haddr_q),
    .size    (Size),
    .pattern (PATTERN != 0),
    .data    (lp_data),
    .mask    (lp_mask)
  );

  assign mismatch = |((HRDATA ^ exp_q) & mask_q);

  // Next-state: pipelined address/data phases, everything frozen while HREADY is low.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hsel_d      = hsel_q;
    hwdata_d    = hwdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    exp_d       = exp_q;
    mask_d      = mask_q;
    issue_cnt_d = issue_cnt_q;
    done_cnt_d  = done_cnt_q;
    errcount_d  = errcount_q;
    chkcount_d  = chkcount_q;

    case (state_q)
      StIdle, StDone: begin
        if (START) begin
          state_d     = StWrite;
          base_d      = STARTADDR;
          haddr_d     = STARTADDR;
          htrans_d    = HTRANS_NONSEQ;
          hwrite_d    = 1'b1;
          hsel_d      = 1'b1;
          dp_valid_d  = 1'b0;
          issue_cnt_d = 17'd1;
          done_cnt_d  = '0;
          errcount_d  = '0;
          chkcount_d  = '0;
        end
      end
      default: begin
        if (HREADY) begin
          // Data phase completion
          if (dp_valid_q) begin
            done_cnt_d = done_cnt_q + 17'd1;
            if (HRESP || (!dp_write_q && mismatch)) begin
              errcount_d = errcount_q + 32'd1;
            end
            if (!dp_write_q && (chkcount_q != 16'hffff)) begin
              chkcount_d = chkcount_q + 16'd1;
            end
          end
          // Address phase acceptance moves the beat into its data phase
          if (htrans_q != HTRANS_IDLE) begin
            dp_valid_d = 1'b1;
            dp_write_d = hwrite_q;
            exp_d      = lp_data;
            mask_d     = lp_mask;
            if (hwrite_q) begin
              hwdata_d = lp_data;
            end
          end else begin
            dp_valid_d = 1'b0;
          end
          // Next address phase
          if (issue_cnt_q < WcTotal) begin
            haddr_d     = haddr_q + AddrInc;
            htrans_d    = NextTrans;
            issue_cnt_d = issue_cnt_q + 17'd1;
          end else begin
            htrans_d = HTRANS_IDLE;
            hsel_d   = 1'b0;
            hwrite_d = 1'b0;
          end
          // End of pass; the idle address cycle sits under the last data phase
          if (dp_valid_q && (done_cnt_q == WcLast)) begin
            done_cnt_d = '0;
            if (state_q == StWrite) begin
              state_d     = StCheck;
              haddr_d     = base_q;
              htrans_d    = HTRANS_NONSEQ;
              hwrite_d    = 1'b0;
              hsel_d      = 1'b1;
              issue_cnt_d = 17'd1;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
    endcase
  end

  // State registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      base_q      <= '0;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsel_q      <= 1'b0;
      hwdata_q    <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      exp_q       <= '0;
      mask_q      <= '0;
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
      errcount_q  <= '0;
      chkcount_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsel_q      <= hsel_d;
      hwdata_q    <= hwdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      exp_q       <= exp_d;
      mask_q      <= mask_d;
      issue_cnt_q <= issue_cnt_d;
      done_cnt_q  <= done_cnt_d;
      errcount_q  <= errcount_d;
      chkcount_q  <= chkcount_d;
    end
  end

  // Outputs
  always_comb begin
    HADDR     = haddr_q;
    HTRANS    = htrans_q;
    HWRITE    = hwrite_q;
    HSEL      = hsel_q;
    HWDATA    = hwdata_q;
    HSIZE     = Size;
    HBURST    = (USE_BURST != 0) ? HBURST_INCR : HBURST_SINGLE;
    ERRCOUNT  = errcount_q;
    CHKCOUNT  = chkcount_q;
    S_WRITE   = (state_q == StWrite);
    S_CHECK   = (state_q == StCheck);
    S_SUCCESS = (state_q == StDone) && (errcount_q == 32'd0);
    S_FAILED  = (state_q == StDone) && (errcount_q != 32'd0);
  end

endmodule

// File: tb/tb_ahb_lite_mem_tester.sv
// Bench for ahb_lite_mem_tester: four parameterisations, each with a small memory slave.
module tb_ahb_lite_mem_tester;

  localparam int NDUT = 4;

  // dut0: 16 words; dut1: 4 bytes, inverted; dut2: 16-word INCR; dut3: 1-word INCR
  function automatic int dwc(int d);
    return (d == 1) ? 4 : (d == 3) ? 1 : 16;
  endfunction
  function automatic int dsz(int d);
    return (d == 1) ? 0 : 2;
  endfunction
  function automatic int dpat(int d);
    return (d == 1) ? 1 : 0;
  endfunction
  function automatic int dburst(int d);
    return (d >= 2) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start     [NDUT];
  logic [31:0] startaddr [NDUT];
  logic [31:0] haddr     [NDUT];
  logic [2:0]  hburst    [NDUT];
  logic [2:0]  hsize     [NDUT];
  logic [1:0]  htrans    [NDUT];
  logic        hwrite    [NDUT];
  logic        hsel      [NDUT];
  logic [31:0] hwdata    [NDUT];
  logic [31:0] hrdata    [NDUT];
  logic        hready    [NDUT];
  logic        hresp     [NDUT];
  logic [31:0] errcount  [NDUT];
  logic [15:0] chkcount  [NDUT];
  logic        s_write   [NDUT];
  logic        s_check   [NDUT];
  logic        s_success [NDUT];
  logic        s_failed  [NDUT];

  // Slave fault controls and data-phase visibility
  int          stall_n    [NDUT];
  logic [31:0] stall_addr [NDUT];
  logic        err_en     [NDUT];
  logic [31:0] err_addr   [NDUT];
  logic        cor_en     [NDUT];
  logic [31:0] cor_addr   [NDUT];
  logic [31:0] cor_mask   [NDUT];
  logic        sdv        [NDUT];
  logic        sdw        [NDUT];
  logic [31:0] sda        [NDUT];

  function automatic logic lane_on(logic [2:0] sz, logic [1:0] lo, int b);
    logic [1:0] bb;
    bb = 2'(b);
    if (sz >= 3'd2) return 1'b1;
    if (sz == 3'd1) return bb[1] == lo[1];
    return bb == lo;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [7:0]  mem [0:1023];
    logic        dv, dw;
    logic [31:0] da;
    logic [2:0]  ds;
    int          st;
    logic [9:0]  wa;

    ahb_lite_mem_tester #(
      .WORD_COUNT (dwc(g)),
      .DATA_SIZE  (dsz(g)),
      .PATTERN    (dpat(g)),
      .USE_BURST  (dburst(g))
    ) dut (
      .HCLK      (clk),
      .HRESETn   (rst_n),
      .START     (start[g]),
      .STARTADDR (startaddr[g]),
      .HADDR     (haddr[g]),
      .HBURST    (hburst[g]),
      .HSIZE     (hsize[g]),
      .HTRANS    (htrans[g]),
      .HWRITE    (hwrite[g]),
      .HSEL      (hsel[g]),
      .HWDATA    (hwdata[g]),
      .HRDATA    (hrdata[g]),
      .HREADY    (hready[g]),
      .HRESP     (hresp[g]),
      .ERRCOUNT  (errcount[g]),
      .CHKCOUNT  (chkcount[g]),
      .S_WRITE   (s_write[g]),
      .S_CHECK   (s_check[g]),
      .S_SUCCESS (s_success[g]),
      .S_FAILED  (s_failed[g])
    );

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dv <= 1'b0; dw <= 1'b0; da <= '0; ds <= '0; st <= 0;
      end else if (st != 0) begin
        st <= st - 1;
      end else begin
        dv <= hsel[g] && htrans[g][1];
        dw <= hwrite[g];
        da <= haddr[g];
        ds <= hsize[g];
        if (hsel[g] && htrans[g][1] && hwrite[g] && (stall_n[g] != 0) &&
            (haddr[g] == stall_addr[g]))
          st <= stall_n[g];
      end
    end

    always @(posedge clk) begin
      if (st == 0 && dv && dw)
        for (int b = 0; b < 4; b++)
          if (lane_on(ds, da[1:0], b)) mem[{da[9:2], 2'(b)}] <= hwdata[g][8*b +: 8];
    end

    assign wa        = {da[9:2], 2'b00};
    assign hready[g] = (st == 0);
    assign hresp[g]  = (st == 0) && dv && dw && err_en[g] && (da == err_addr[g]);
    assign hrdata[g] = {mem[wa + 10'd3], mem[wa + 10'd2], mem[wa + 10'd1], mem[wa]} ^
                       ((dv && !dw && cor_en[g] && (da == cor_addr[g])) ? cor_mask[g] : 32'd0);
    assign sdv[g] = dv;
    assign sdw[g] = dw;
    assign sda[g] = da;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_data(int d, logic [31:0] a);
    logic [31:0] p;
    p = (dpat(d) != 0) ? ~a : a;
    if (dsz(d) == 0) return {4{p[7:0]}};
    if (dsz(d) == 1) return {2{p[15:0]}};
    return p;
  endfunction

  typedef struct {
    int          d;
    logic [31:0] saddr;
    int          stall;
    logic [31:0] stall_a;
    logic        err;
    logic [31:0] err_a;
    logic        cor;
    logic [31:0] cor_a;
    logic [31:0] cor_m;
    int          poke;
    int          exp_err;
    int          exp_chk;
    logic        exp_ok;
  } vec_t;

  task automatic run_pass(input vec_t v);
    int          d, wc, acc, stalls, idx;
    logic        done, prev_rdy, prev_wr;
    logic [31:0] prev_addr, prev_wd, ea;
    logic [1:0]  prev_tr, et;
    d = v.d;
    wc = dwc(d);
    stall_n[d] = v.stall; stall_addr[d] = v.stall_a;
    err_en[d] = v.err; err_addr[d] = v.err_a;
    cor_en[d] = v.cor; cor_addr[d] = v.cor_a; cor_mask[d] = v.cor_m;
    startaddr[d] = v.saddr;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    chk("s_write_on_start", 32'(s_write[d]), 32'd1);
    acc = 0; stalls = 0; done = 1'b0; prev_rdy = 1'b1;
    prev_addr = '0; prev_wd = '0; prev_tr = '0; prev_wr = 1'b0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      if (!prev_rdy) begin
        chk("hold_haddr", haddr[d], prev_addr);
        chk("hold_htrans", 32'(htrans[d]), 32'(prev_tr));
        chk("hold_hwrite", 32'(hwrite[d]), 32'(prev_wr));
        chk("hold_hwdata", hwdata[d], prev_wd);
      end
      if (!hready[d]) stalls++;
      if (htrans[d] != 2'b00 && hready[d]) begin
        idx = acc % wc;
        ea = v.saddr + 32'(idx << dsz(d));
        et = (idx == 0 || dburst(d) == 0) ? 2'b10 : 2'b11;
        chk("haddr", haddr[d], ea);
        chk("htrans", 32'(htrans[d]), 32'(et));
        chk("hwrite", 32'(hwrite[d]), (acc < wc) ? 32'd1 : 32'd0);
        chk("hsel", 32'(hsel[d]), 32'd1);
        chk("hsize", 32'(hsize[d]), 32'(dsz(d)));
        chk("hburst", 32'(hburst[d]), 32'(dburst(d)));
        if (acc == wc) begin
          chk("s_check_first_read", 32'(s_check[d]), 32'd1);
          chk("s_write_first_read", 32'(s_write[d]), 32'd0);
        end
        acc++;
      end
      if (sdv[d] && sdw[d] && hready[d]) chk("hwdata", hwdata[d], model_data(d, sda[d]));
      prev_rdy = hready[d]; prev_addr = haddr[d]; prev_tr = htrans[d];
      prev_wr = hwrite[d]; prev_wd = hwdata[d];
      if (s_success[d] || s_failed[d]) done = 1'b1;
      else begin
        if (v.poke != 0 && cyc == v.poke) start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL pass_timeout dut%0d: no done flag within cycle budget", d);
    end else begin
      chk("errcount", errcount[d], 32'(v.exp_err));
      chk("chkcount", 32'(chkcount[d]), 32'(v.exp_chk));
      chk("s_success", 32'(s_success[d]), 32'(v.exp_ok));
      chk("s_failed", 32'(s_failed[d]), 32'(!v.exp_ok));
      chk("beats_accepted", 32'(acc), 32'(2 * wc));
      chk("stall_cycles", 32'(stalls), 32'(v.stall));
      chk("htrans_done", 32'(htrans[d]), 32'd0);
      chk("hsel_done", 32'(hsel[d]), 32'd0);
    end
  endtask

  task automatic check_reset(input int d);
    chk("rst_htrans", 32'(htrans[d]), 32'd0);
    chk("rst_hsel", 32'(hsel[d]), 32'd0);
    chk("rst_hwrite", 32'(hwrite[d]), 32'd0);
    chk("rst_haddr", haddr[d], 32'd0);
    chk("rst_hwdata", hwdata[d], 32'd0);
    chk("rst_errcount", errcount[d], 32'd0);
    chk("rst_chkcount", 32'(chkcount[d]), 32'd0);
    chk("rst_flags", 32'({s_write[d], s_check[d], s_success[d], s_failed[d]}), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    //            d  saddr       stall st_a        err err_a      cor cor_a      cor_m    poke err chk ok
    vecs[0] = '{0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,   0, 0, 16, 1};
    vecs[1] = '{0, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h108, 32'h1,   0, 1, 16, 0};
    vecs[2] = '{0, 32'h100, 3, 32'h114, 0, 32'h0,   0, 32'h0,   32'h0,   8, 0, 16, 1};
    vecs[3] = '{1, 32'h3,   0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,   0, 0, 4,  1};
    vecs[4] = '{1, 32'h3,   0, 32'h0,   0, 32'h0,   1, 32'h4,   32'h100, 0, 0, 4,  1};
    vecs[5] = '{1, 32'h3,   0, 32'h0,   0, 32'h0,   1, 32'h4,   32'h1,   0, 1, 4,  0};
    vecs[6] = '{2, 32'h100, 0, 32'h0,   1, 32'h108, 0, 32'h0,   32'h0,   0, 1, 16, 0};
    vecs[7] = '{3, 32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,   0, 0, 1,  1};

    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      start[d] = 1'b0; startaddr[d] = '0;
      stall_n[d] = 0; stall_addr[d] = '0;
      err_en[d] = 1'b0; err_addr[d] = '0;
      cor_en[d] = 1'b0; cor_addr[d] = '0; cor_mask[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) check_reset(d);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_pass(vecs[i]);
      repeat (2) @(negedge clk);
    end

    // Reset in the middle of the check pass, then a fresh pass
    stall_n[0] = 0; err_en[0] = 1'b0; cor_en[0] = 1'b0;
    startaddr[0] = 32'h100;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    begin
      int n;
      n = 0;
      while (!(s_check[0] && chkcount[0] == 16'd7) && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) begin
        total++; bad++;
        $display("FAIL midpass_wait: chkcount %0d never reached 7", chkcount[0]);
      end
    end
    rst_n = 1'b0;
    #1;
    check_reset(0);
    repeat (2) @(negedge clk);
    check_reset(0);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset(0);
    run_pass(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_mem_tester.md
AHB_LITE_MEM_TESTER -- requirements
Module: ahb_lite_mem_tester

Interface
REQ-001 Parameter WORD_COUNT, default 16: number of transfers per pass, range 1..65535.
REQ-002 Parameter DATA_SIZE, default 2: HSIZE used for every transfer (0 = byte, 1 = halfword, 2 = word).
REQ-003 Parameter PATTERN, default 0: data pattern (0 = address, 1 = inverted address).
REQ-004 Parameter USE_BURST, default 0: 0 = SINGLE transfers, all NONSEQ; 1 = INCR burst, first beat NONSEQ and rest SEQ.
REQ-005 HCLK  in  1  bus clock, single clock domain.
REQ-006 HRESETn  in  1  asynchronous active-low reset.
REQ-007 START  in  1  one-cycle pulse that begins a write pass followed by a check pass.
REQ-008 STARTADDR  in  32  base byte address, sampled on START, aligned to 1<<DATA_SIZE.
REQ-009 HADDR / HBURST / HSIZE / HTRANS / HWRITE / HSEL  out  32/3/3/2/1/1  AHB-Lite master address phase.
REQ-010 HWDATA  out  32  write data, driven in the data phase.
REQ-011 HRDATA  in  32  read data; HREADY  in  1  transfer complete; HRESP  in  1  1 = ERROR.
REQ-012 ERRCOUNT  out  32  number of mismatches plus ERROR responses.
REQ-013 CHKCOUNT  out  16  number of read beats completed.
REQ-014 S_WRITE, S_CHECK, S_SUCCESS, S_FAILED  out  1 each  one-hot status flags.

Function
REQ-015 State machine SHALL have states IDLE, WRITE, CHECK and DONE: IDLE->WRITE on START, WRITE->CHECK after the last write data phase completes, CHECK->DONE after the last read data phase completes, DONE->WRITE on START.
REQ-016 Beat i (0..WORD_COUNT-1) SHALL use address A(i) = STARTADDR + i*(1<<DATA_SIZE), modulo 2^32 (wrap-around permitted).
REQ-017 Pattern P(i) SHALL be A(i) for PATTERN 0 and ~A(i) for PATTERN 1; for byte and halfword sizes the low 8 or 16 bits of P(i) are replicated across all lanes of HWDATA.
REQ-018 Address and data phases SHALL be pipelined: the address of beat i+1 is issued in the same cycle as the data phase of beat i, giving one beat per HREADY-high cycle.
REQ-019 While HREADY is low, HADDR, HTRANS, HWRITE, HSIZE, HBURST and HWDATA SHALL hold their values.
REQ-020 HTRANS SHALL be IDLE (0) and HSEL 0 in IDLE and DONE states and for one cycle between the write and check passes; HBURST SHALL be 0 for SINGLE and 1 for INCR.
REQ-021 In CHECK, each completed beat SHALL compare only the active lanes, selected little-endian by A(i)[1:0], against P(i), and SHALL increment ERRCOUNT on mismatch.
REQ-022 Any data phase with HREADY=1 and HRESP=1 SHALL increment ERRCOUNT once, in either pass, and SHALL not also count a mismatch for that beat.
REQ-023 CHKCOUNT SHALL increment once per completed read beat and saturate at 0xFFFF.
REQ-024 Status flags: S_WRITE=1 in WRITE, S_CHECK=1 in CHECK; in DONE, S_SUCCESS=1 if ERRCOUNT==0, else S_FAILED=1; all flags are 0 in IDLE.
REQ-025 START while in WRITE or CHECK SHALL be ignored; START in DONE SHALL clear ERRCOUNT and CHKCOUNT in the same cycle it begins the new pass.
REQ-026 When WORD_COUNT=1 and USE_BURST=1, the block SHALL issue a single NONSEQ beat with HBURST=1.

Reset
REQ-027 Asserting HRESETn low SHALL force IDLE, HTRANS=0, HSEL=0, HWRITE=0, HADDR=0, HWDATA=0, ERRCOUNT=0, CHKCOUNT=0 and all status flags 0, including when asserted mid-pass; the aborted pass is not resumed.

Structure
REQ-028 A shared package ahb_lite_pkg SHALL hold HTRANS codes (IDLE/NONSEQ/SEQ), HBURST codes (SINGLE/INCR) and HSIZE codes.
REQ-029 Lane masking and pattern generation SHALL be one sub-module, ahb_lite_lane_pattern (combinational; inputs A(i), DATA_SIZE, PATTERN; outputs data and lane mask).

Verification
REQ-030 With WORD_COUNT=16, DATA_SIZE=2, STARTADDR=0x100 and a zero-wait slave: 16 writes to 0x100..0x13C, then 16 reads; end state S_SUCCESS=1, ERRCOUNT=0, CHKCOUNT=16.
REQ-031 Same setup with the slave inserting 3 wait states on beat 5: all outputs stable during the wait, and S_SUCCESS=1 at the end.
REQ-032 With the slave corrupting bit 0 of the read data at 0x108: ERRCOUNT=1 and S_FAILED=1.
REQ-033 With DATA_SIZE=0, PATTERN=1, STARTADDR=0x3, WORD_COUNT=4: HWDATA lanes replicate ~A[7:0]; the compare uses only the byte lane for addresses 3, 4, 5 and 6; the pass succeeds.
REQ-034 With USE_BURST=1 and HRESP=1 on write beat 2: ERRCOUNT=1 and S_FAILED=1; HTRANS sequence is NONSEQ followed by SEQ beats.
REQ-035 Reset asserted in CHECK at beat 7, then START: outputs return to reset values, and the new pass completes with S_SUCCESS=1 and CHKCOUNT=16.
